// File: rtl/tslink_pkg.sv
// Package: tslink_pkg
// Shared definitions for the two-lane trigger-scintillator GTX link sequencer:
// FSM state encoding, counter width, cpll_status bit positions and the
// comma/reset-done constants used by tslink_ctrl and tslink_lane_mon.
package tslink_pkg;

    // Wide enough for every timeout/window length (LOCK_TO, ALIGN_TO, ERR_WIN).
    localparam int CNT_W = 20;

    // cpll_status = {lock1, fblost1, lock0, fblost0}
    localparam int FBLOST0_BIT = 0;
    localparam int LOCK0_BIT   = 1;
    localparam int FBLOST1_BIT = 2;
    localparam int LOCK1_BIT   = 3;

    // K28.5 comma character as presented on the RX data bus.
    localparam logic [7:0] K28_5 = 8'hBC;

    // All GTX FSM/TX/RX reset-done flags asserted.
    localparam logic [7:0] RST_DONE_ALL = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CPLL_RST  = 3'd1,
        ST_CPLL_WAIT = 3'd2,
        ST_GT_RST    = 3'd3,
        ST_DONE_WAIT = 3'd4,
        ST_ALIGN     = 3'd5,
        ST_UP        = 3'd6,
        ST_RX_RST    = 3'd7
    } state_e;

    // Lane monitors only run while aligning or while the link is up.
    function automatic logic lanes_active(input state_e s);
        return (s == ST_ALIGN) || (s == ST_UP);
    endfunction

endpackage

// File: rtl/tslink_lane_mon.sv
// Module: tslink_lane_mon
// Per-lane alignment and error-rate monitor.
//  - Unlocked: counts consecutive good cycles (comma seen, no error); after
//    GOOD_CYC of them the lane locks. If ALIGN_TO cycles pass without lock the
//    RX polarity is toggled and the search restarts.
//  - Locked: counts errors per ERR_WIN-cycle window; more than ERR_MAX errors
//    in one window drops the lock (polarity is kept).
// Ports:
//  clk_125  in   clock
//  reset    in   synchronous active-high clear, also clears polarity
//  run      in   1 while the lane is being monitored; 0 clears lock and counters
//  err      in   disparity / not-in-table error this cycle
//  comma    in   K28.5 seen this cycle
//  locked   out  lane locked (registered)
//  pol      out  RX polarity for this lane (registered)
module tslink_lane_mon
    import tslink_pkg::*;
#(
    parameter int ALIGN_TO = 65536,
    parameter int GOOD_CYC = 256,
    parameter int ERR_WIN  = 65536,
    parameter int ERR_MAX  = 4
) (
    input  logic clk_125,
    input  logic reset,
    input  logic run,
    input  logic err,
    input  logic comma,
    output logic locked,
    output logic pol
);

    localparam logic [CNT_W-1:0] GOOD_LAST  = CNT_W'(GOOD_CYC - 1);
    localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_TO - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(ERR_WIN - 1);
    localparam logic [7:0]       ERR_LIM    = 8'(ERR_MAX);

    logic             locked_q, locked_d;
    logic             pol_q, pol_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] align_q, align_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [7:0]       err_q, err_d;
    logic [7:0]       err_new;
    logic             good;

    assign good = comma & ~err;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        locked_d = locked_q;
        pol_d    = pol_q;
        good_d   = good_q;
        align_d  = align_q;
        win_d    = win_q;
        err_d    = err_q;
        err_new  = err_q;

        if (!run) begin
            locked_d = 1'b0;
            good_d   = '0;
            align_d  = '0;
            win_d    = '0;
            err_d    = '0;
        end else if (!locked_q) begin
            // Align timeout beats a lock completing on the same cycle.
            if (align_q == ALIGN_LAST) begin
                pol_d   = ~pol_q;
                align_d = '0;
                good_d  = '0;
            end else begin
                align_d = align_q + 1'b1;
                if (!good) begin
                    good_d = '0;
                end else if (good_q == GOOD_LAST) begin
                    locked_d = 1'b1;
                    good_d   = '0;
                    win_d    = '0;
                    err_d    = '0;
                end else begin
                    good_d = good_q + 1'b1;
                end
            end
        end else begin
            if (win_q == WIN_LAST) begin
                // An error on the closing cycle is charged to the new window.
                win_d   = '0;
                err_new = {7'd0, err};
            end else begin
                win_d   = win_q + 1'b1;
                err_new = (err && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
            end
            err_d = err_new;
            if (err_new > ERR_LIM) begin
                locked_d = 1'b0;
                win_d    = '0;
                err_d    = '0;
                good_d   = '0;
                align_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_125) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            locked_q <= 1'b0;
            pol_q    <= 1'b0;
            good_q   <= '0;
            align_q  <= '0;
            win_q    <= '0;
            err_q    <= '0;
        end else begin
            locked_q <= locked_d;
            pol_q    <= pol_d;
            good_q   <= good_d;
            align_q  <= align_d;
            win_q    <= win_d;
            err_q    <= err_d;
        end
    end

    assign locked = locked_q;
    assign pol    = pol_q;

endmodule

// File: rtl/tslink_ctrl.sv
// Module: tslink_ctrl
// Bring-up and supervision sequencer for the two-lane GTX link:
// CPLL reset -> CPLL lock -> GTX soft reset -> reset-done wait -> per-lane
// comma alignment (with RX polarity search) -> link up, then supervision with
// RX-only or full re-runs on faults.
// Ports:
//  clk_125      in   clock
//  reset        in   synchronous active-high reset
//  enable       in   0 forces IDLE, 1 runs the sequence
//  cpll_status  in   {lock1, fblost1, lock0, fblost0}
//  reset_done   in   GTX reset-done flags
//  rx_err_s     in   per-lane RX error, synchronised
//  rx_comma_s   in   per-lane K28.5 seen, synchronised
//  cpll_reset   out  CPLL reset to GTX
//  reset_soft   out  GTX soft reset
//  reset_rx     out  GTX RX reset
//  polarity     out  per-lane RX polarity
//  link_up      out  per-lane locked
//  state        out  FSM state encoding
//  retry_cnt    out  full-sequence restarts, saturating
module tslink_ctrl
    import tslink_pkg::*;
#(
    parameter int CPLL_RST_CYC = 16,
    parameter int SOFT_RST_CYC = 16,
    parameter int RX_RST_CYC   = 16,
    parameter int LOCK_TO      = 65536,
    parameter int ALIGN_TO     = 65536,
    parameter int GOOD_CYC     = 256,
    parameter int ERR_WIN      = 65536,
    parameter int ERR_MAX      = 4
) (
    input  logic       clk_125,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] cpll_status,
    input  logic [7:0] reset_done,
    input  logic [1:0] rx_err_s,
    input  logic [1:0] rx_comma_s,
    output logic       cpll_reset,
    output logic       reset_soft,
    output logic       reset_rx,
    output logic [1:0] polarity,
    output logic [1:0] link_up,
    output logic [2:0] state,
    output logic [7:0] retry_cnt
);

    localparam logic [CNT_W-1:0] CPLL_LAST = CNT_W'(CPLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_RST_CYC - 1);
    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TO - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [3:0]       stat_q;
    logic             cpll_reset_q, reset_soft_q, reset_rx_q;
    logic             retry_inc;
    logic             lock_ok, pll_good, supervised;
    logic             run, mon_clr;
    logic [1:0]       lane_locked, lane_pol;

    assign lock_ok  = stat_q[LOCK1_BIT] & stat_q[LOCK0_BIT];
    assign pll_good = lock_ok & ~stat_q[FBLOST1_BIT] & ~stat_q[FBLOST0_BIT];

    // Lock-loss supervision applies once the CPLL has been seen locked; in
    // CPLL_WAIT a missing lock is simply what is being waited for.
    assign supervised = (state_q == ST_GT_RST) || (state_q == ST_DONE_WAIT) ||
                        (state_q == ST_ALIGN)  || (state_q == ST_UP);

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else if (supervised && !lock_ok) begin
            state_d   = ST_CPLL_RST;
            retry_inc = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE:      state_d = ST_CPLL_RST;
                ST_CPLL_RST:  if (cnt_q == CPLL_LAST) state_d = ST_CPLL_WAIT;
                ST_CPLL_WAIT: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d   = ST_CPLL_RST;
                        retry_inc = 1'b1;
                    end else if (pll_good) begin
                        state_d = ST_GT_RST;
                    end
                end
                ST_GT_RST:    if (cnt_q == SOFT_LAST) state_d = ST_DONE_WAIT;
                ST_DONE_WAIT: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d   = ST_CPLL_RST;
                        retry_inc = 1'b1;
                    end else if (reset_done == RST_DONE_ALL) begin
                        state_d = ST_ALIGN;
                    end
                end
                ST_ALIGN:     if (&lane_locked) state_d = ST_UP;
                ST_UP:        if (!(&lane_locked)) state_d = ST_RX_RST;
                ST_RX_RST:    if (cnt_q == RX_LAST) state_d = ST_ALIGN;
                default:      state_d = ST_IDLE;
            endcase
        end

        retry_d = (retry_inc && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
        cnt_d   = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // Monitors count only on cycles spent inside ALIGN/UP and are cleared on
    // the same edge the FSM leaves them, so link_up drops with the state.
    assign run     = lanes_active(state_q) && lanes_active(state_d);
    // Polarity survives RX_RST and CPLL re-runs; only IDLE or reset clears it.
    assign mon_clr = reset || (state_d == ST_IDLE);

    always_ff @(posedge clk_125) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            stat_q       <= '0;
            cpll_reset_q <= 1'b0;
            reset_soft_q <= 1'b0;
            reset_rx_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            stat_q       <= cpll_status;
            cpll_reset_q <= (state_d == ST_CPLL_RST);
            reset_soft_q <= (state_d == ST_GT_RST);
            reset_rx_q   <= (state_d == ST_RX_RST);
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_lane
        tslink_lane_mon #(
            .ALIGN_TO (ALIGN_TO),
            .GOOD_CYC (GOOD_CYC),
            .ERR_WIN  (ERR_WIN),
            .ERR_MAX  (ERR_MAX)
        ) u_mon (
            .clk_125 (clk_125),
            .reset   (mon_clr),
            .run     (run),
            .err     (rx_err_s[i]),
            .comma   (rx_comma_s[i]),
            .locked  (lane_locked[i]),
            .pol     (lane_pol[i])
        );
    end

    assign cpll_reset = cpll_reset_q;
    assign reset_soft = reset_soft_q;
    assign reset_rx   = reset_rx_q;
    assign polarity   = lane_pol;
    assign link_up    = lane_locked;
    assign state      = state_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_tslink_ctrl.sv
// Testbench: tb_tslink_ctrl
// Directed bring-up, timeout, polarity-search, error-burst, lock-loss and
// control scenarios for tslink_ctrl with shortened timing parameters.
module tb_tslink_ctrl;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CPLL_RST  = 3'd1;
    localparam logic [2:0] S_DONE_WAIT = 3'd4;
    localparam logic [2:0] S_ALIGN     = 3'd5;
    localparam logic [2:0] S_UP        = 3'd6;

    logic       clk_125;
    logic       reset;
    logic       enable;
    logic [3:0] cpll_status;
    logic [7:0] reset_done;
    logic [1:0] rx_err_s;
    logic [1:0] rx_comma_s;
    logic       cpll_reset;
    logic       reset_soft;
    logic       reset_rx;
    logic [1:0] polarity;
    logic [1:0] link_up;
    logic [2:0] state;
    logic [7:0] retry_cnt;

    logic [1:0] comma_en;
    logic       inv1;
    int         cyc;
    int         n_checks;
    int         n_err;

    // Lane 1 channel model: when inverted, commas decode only once the
    // receiver polarity has been flipped.
    assign rx_comma_s = {comma_en[1] & (inv1 ? polarity[1] : 1'b1), comma_en[0]};

    tslink_ctrl #(
        .CPLL_RST_CYC (4),
        .SOFT_RST_CYC (4),
        .RX_RST_CYC   (4),
        .LOCK_TO      (64),
        .ALIGN_TO     (32),
        .GOOD_CYC     (8),
        .ERR_WIN      (32),
        .ERR_MAX      (2)
    ) dut (
        .clk_125     (clk_125),
        .reset       (reset),
        .enable      (enable),
        .cpll_status (cpll_status),
        .reset_done  (reset_done),
        .rx_err_s    (rx_err_s),
        .rx_comma_s  (rx_comma_s),
        .cpll_reset  (cpll_reset),
        .reset_soft  (reset_soft),
        .reset_rx    (reset_rx),
        .polarity    (polarity),
        .link_up     (link_up),
        .state       (state),
        .retry_cnt   (retry_cnt)
    );

    initial clk_125 = 1'b0;
    always #5 clk_125 = ~clk_125;

    always @(posedge clk_125) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_125);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rst_sig(input int sel);
        case (sel)
            0:       return cpll_reset;
            1:       return reset_soft;
            default: return reset_rx;
        endcase
    endfunction

    // Waits for the selected reset output to rise, then returns how many
    // consecutive sampled cycles it stayed high (-1 if it never rose).
    task automatic measure_pulse(input int sel, output int width);
        int n;
        n = 0;
        while (!rst_sig(sel) && n < 300) begin
            tick();
            n++;
        end
        if (!rst_sig(sel)) begin
            width = -1;
        end else begin
            width = 0;
            while (rst_sig(sel) && width < 300) begin
                tick();
                width++;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
        int n;
        n = 0;
        while (state !== s && n < limit) begin
            tick();
            n++;
        end
        check(tag, state, s);
    endtask

    initial begin
        int w;
        int n;
        int n0;
        int t0;

        n_checks    = 0;
        n_err       = 0;
        cyc         = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        cpll_status = 4'b0000;
        reset_done  = 8'h00;
        rx_err_s    = 2'b00;
        comma_en    = 2'b11;
        inv1        = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset_state", state, S_IDLE);
        check("reset_outputs", {cpll_reset, reset_soft, reset_rx, polarity, link_up}, 0);
        check("reset_retry", retry_cnt, 0);
        reset = 1'b0;
        tick();
        check("idle_disabled", state, S_IDLE);

        // CPLL timeout: locks never rise
        enable = 1'b1;
        measure_pulse(0, w);
        check("timeout_cpll_hold", w, 4);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!cpll_reset && n < 200) begin
                tick();
                n++;
            end
            check("timeout_wait_len", n, 64);
            check("timeout_retry", retry_cnt, i + 1);
            check("timeout_state", state, S_CPLL_RST);
            measure_pulse(0, w);
            check("timeout_cpll_rehold", w, 4);
        end

        // enable=0 keeps retry_cnt, reset clears it
        enable = 1'b0;
        tick();
        check("disable_state", state, S_IDLE);
        check("disable_cpll_reset", cpll_reset, 0);
        check("disable_retry_kept", retry_cnt, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_clears_retry", retry_cnt, 0);

        // Nominal bring-up
        enable = 1'b1;
        measure_pulse(0, w);
        check("nom_cpll_hold", w, 4);
        repeat (10) tick();
        cpll_status = 4'b1010;
        measure_pulse(1, w);
        check("nom_soft_hold", w, 4);
        check("nom_done_wait", state, S_DONE_WAIT);
        repeat (20) tick();
        reset_done = 8'hFF;
        n = 0;
        while (link_up !== 2'b11 && n < 100) begin
            tick();
            n++;
        end
        check("nom_link_up", link_up, 2'b11);
        tick();
        check("nom_state_up", state, S_UP);
        check("nom_retry", retry_cnt, 0);
        check("nom_polarity", polarity, 2'b00);

        // Lock loss in UP: lock0 low for one cycle
        cpll_status[1] = 1'b0;
        tick();
        cpll_status[1] = 1'b1;
        tick();
        check("lockloss_state", state, S_CPLL_RST);
        check("lockloss_link_up", link_up, 2'b00);
        check("lockloss_retry", retry_cnt, 1);
        wait_state(S_UP, 200, "lockloss_recover_up");

        // enable=0 in the middle of ALIGN
        enable = 1'b0;
        tick();
        enable = 1'b1;
        inv1   = 1'b1;
        wait_state(S_ALIGN, 100, "ctl_reach_align");
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check("ctl_idle_next", state, S_IDLE);
        check("ctl_outputs_zero", {cpll_reset, reset_soft, reset_rx, polarity, link_up}, 0);
        check("ctl_retry_kept", retry_cnt, 1);

        // Inverted lane 1: polarity search
        enable = 1'b1;
        wait_state(S_ALIGN, 100, "inv_reach_align");
        n  = 0;
        n0 = -1;
        t0 = 0;
        while (!polarity[1] && n < 100) begin
            tick();
            n++;
            if (link_up[0] && n0 < 0) begin
                n0 = n;
                t0 = cyc;
            end
        end
        check("inv_pol_toggle_cycles", n, 32);
        check("inv_lane0_lock_cycles", n0, 8);
        check("inv_pol0_kept", polarity[0], 0);
        n = 0;
        while (!link_up[1] && n < 50) begin
            tick();
            n++;
        end
        check("inv_lane1_lock_cycles", n, 8);
        tick();
        check("inv_state_up", state, S_UP);

        // Error bursts on lane 0, positioned relative to its error window
        n = 0;
        while (((cyc - t0) % 32) != 4 && n < 40) begin
            tick();
            n++;
        end
        rx_err_s[0] = 1'b1;
        repeat (2) tick();
        rx_err_s[0] = 1'b0;
        repeat (10) tick();
        check("two_errors_no_drop", link_up, 2'b11);
        n = 0;
        while (((cyc - t0) % 32) != 4 && n < 40) begin
            tick();
            n++;
        end
        rx_err_s[0] = 1'b1;
        repeat (3) tick();
        rx_err_s[0] = 1'b0;
        n = 0;
        while (link_up[0] && n < 10) begin
            tick();
            n++;
        end
        check("burst_link_drop", link_up[0], 0);
        measure_pulse(2, w);
        check("burst_rx_rst_hold", w, 4);
        check("burst_pol_during", polarity, 2'b10);
        n = 0;
        while (link_up !== 2'b11 && n < 60) begin
            tick();
            n++;
        end
        check("burst_realign", link_up, 2'b11);
        tick();
        check("burst_state_up", state, S_UP);
        check("burst_pol_held", polarity, 2'b10);
        check("burst_retry_same", retry_cnt, 1);

        // Final reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("final_reset_retry", retry_cnt, 0);
        check("final_reset_state", state, S_IDLE);
        check("final_reset_pol", polarity, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
